// File: rtl/alu_check_pkg.sv
// ============================================================================
// Module  : alu_check_pkg
// Purpose : Shared types and field layout for the ALU_System response checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ARMED = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int FIELD_N = 7;
    localparam int ENTRY_W = 68;
    localparam int OBS_W   = 60;

    // Expected[59:0] layout, MSB to LSB: AOut, BOut, ALUOut, flags, Address, MemoryOut, IROut
    localparam int AOUT_LSB = 52;
    localparam int BOUT_LSB = 44;
    localparam int ALU_LSB  = 36;
    localparam int FLAG_LSB = 32;
    localparam int ADDR_LSB = 24;
    localparam int MEM_LSB  = 16;
    localparam int IR_LSB   = 0;

    localparam int LAST_BIT   = 67;
    localparam int FEN_LSB    = 60;

    function automatic logic [OBS_W-1:0] pack_obs(
        input logic [7:0]  a_out,
        input logic [7:0]  b_out,
        input logic [7:0]  alu_out,
        input logic [3:0]  flags,
        input logic [7:0]  address,
        input logic [7:0]  mem_out,
        input logic [15:0] ir_out
    );
        return {a_out, b_out, alu_out, flags, address, mem_out, ir_out};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_field_compare.sv
// ============================================================================
// Module  : alu_field_compare
// Purpose : Per-field masked compare of observed vs expected ALU_System buses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_field_compare
    import alu_check_pkg::*;
(
    input  logic [OBS_W-1:0]   obs,
    input  logic [OBS_W-1:0]   exp_val,
    input  logic [FIELD_N-1:0] field_en,
    output logic [FIELD_N-1:0] mismatch
);

    logic [FIELD_N-1:0] w_raw;

    always_comb begin
        w_raw    = '0;
        w_raw[6] = obs[AOUT_LSB +: 8]  != exp_val[AOUT_LSB +: 8];
        w_raw[5] = obs[BOUT_LSB +: 8]  != exp_val[BOUT_LSB +: 8];
        w_raw[4] = obs[ALU_LSB  +: 8]  != exp_val[ALU_LSB  +: 8];
        w_raw[3] = obs[FLAG_LSB +: 4]  != exp_val[FLAG_LSB +: 4];
        w_raw[2] = obs[ADDR_LSB +: 8]  != exp_val[ADDR_LSB +: 8];
        w_raw[1] = obs[MEM_LSB  +: 8]  != exp_val[MEM_LSB  +: 8];
        w_raw[0] = obs[IR_LSB   +: 16] != exp_val[IR_LSB   +: 16];
        mismatch = w_raw & field_en;
    end

endmodule

`default_nettype wire

// File: rtl/alu_system_response_checker.sv
// ============================================================================
// Module  : alu_system_response_checker
// Purpose : Strobed compare of ALU_System outputs against an expected list.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_system_response_checker
    import alu_check_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 16
)(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                SampleValid,
    input  logic [7:0]          AOut,
    input  logic [7:0]          BOut,
    input  logic [7:0]          ALUOut,
    input  logic [3:0]          ALUOutFlag,
    input  logic [7:0]          Address,
    input  logic [7:0]          MemoryOut,
    input  logic [15:0]         IROut,
    output logic                ExpRd,
    output logic [ADDR_W-1:0]   ExpAddr,
    input  logic [ENTRY_W-1:0]  ExpData,
    output logic                Busy,
    output logic                Done,
    output logic                Pass,
    output logic [ERR_W-1:0]    ErrCount,
    output logic [ERR_W-1:0]    VectorCount,
    output logic [ADDR_W-1:0]   FirstErrIndex,
    output logic [FIELD_N-1:0]  FirstErrFields,
    output logic                Overrun,
    output logic                DroppedSample
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    exp_addr_q, exp_addr_d;
    logic [ENTRY_W-1:0]   exp_q, exp_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic [ERR_W-1:0]     vec_count_q, vec_count_d;
    logic [ADDR_W-1:0]    first_idx_q, first_idx_d;
    logic [FIELD_N-1:0]   first_fields_q, first_fields_d;
    logic                 overrun_q, overrun_d;
    logic                 dropped_q, dropped_d;
    logic                 pass_q, pass_d;

    logic [OBS_W-1:0]     w_obs;
    logic [FIELD_N-1:0]   w_mm;
    logic                 w_any_mm;
    logic                 w_last;
    logic                 w_start_ok;
    logic                 w_check;
    logic                 w_addr_max;

    assign w_obs      = pack_obs(AOut, BOut, ALUOut, ALUOutFlag, Address, MemoryOut, IROut);
    assign w_any_mm   = |w_mm;
    assign w_last     = exp_q[LAST_BIT];
    assign w_start_ok = Start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign w_check    = SampleValid && (state_q == ST_ARMED);
    assign w_addr_max = (exp_addr_q == {ADDR_W{1'b1}});

    alu_field_compare u_cmp (
        .obs      (w_obs),
        .exp_val  (exp_q[OBS_W-1:0]),
        .field_en (exp_q[FEN_LSB +: FIELD_N]),
        .mismatch (w_mm)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q        <= ST_IDLE;
            exp_addr_q     <= '0;
            exp_q          <= '0;
            err_count_q    <= '0;
            vec_count_q    <= '0;
            first_idx_q    <= '0;
            first_fields_q <= '0;
            overrun_q      <= 1'b0;
            dropped_q      <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            exp_addr_q     <= exp_addr_d;
            exp_q          <= exp_d;
            err_count_q    <= err_count_d;
            vec_count_q    <= vec_count_d;
            first_idx_q    <= first_idx_d;
            first_fields_q <= first_fields_d;
            overrun_q      <= overrun_d;
            dropped_q      <= dropped_d;
            pass_q         <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (Start) state_d = ST_FETCH;
            ST_FETCH:         state_d = ST_LOAD;
            ST_LOAD:          state_d = ST_ARMED;
            ST_ARMED: begin
                if (SampleValid) state_d = (w_last || w_addr_max) ? ST_DONE : ST_FETCH;
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        exp_addr_d     = exp_addr_q;
        exp_d          = exp_q;
        err_count_d    = err_count_q;
        vec_count_d    = vec_count_q;
        first_idx_d    = first_idx_q;
        first_fields_d = first_fields_q;
        overrun_d      = overrun_q;
        dropped_d      = dropped_q;
        pass_d         = pass_q;

        if (w_start_ok) begin
            exp_addr_d     = '0;
            err_count_d    = '0;
            vec_count_d    = '0;
            first_idx_d    = '0;
            first_fields_d = '0;
            overrun_d      = 1'b0;
            dropped_d      = 1'b0;
            pass_d         = 1'b0;
        end

        if (state_q == ST_LOAD) exp_d = ExpData;

        if (w_check) begin
            if (vec_count_q != {ERR_W{1'b1}}) vec_count_d = vec_count_q + 1'b1;
            if (w_any_mm) begin
                if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + 1'b1;
                if (err_count_q == '0) begin
                    first_idx_d    = exp_addr_q;
                    first_fields_d = w_mm;
                end
            end
            // Pass is resolved on the same edge that enters DONE
            if (w_last) begin
                pass_d = (err_count_q == '0) && !w_any_mm && !overrun_q;
            end else if (w_addr_max) begin
                overrun_d = 1'b1;
                pass_d    = 1'b0;
            end else begin
                exp_addr_d = exp_addr_q + 1'b1;
            end
        end

        // A sample that cannot be checked is still recorded, even alongside Start
        if (SampleValid && state_q != ST_ARMED) dropped_d = 1'b1;
    end

    always_comb begin
        ExpRd = (state_q == ST_FETCH);
        Busy  = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_ARMED);
        Done  = (state_q == ST_DONE);
    end

    assign ExpAddr        = exp_addr_q;
    assign Pass           = pass_q;
    assign ErrCount       = err_count_q;
    assign VectorCount    = vec_count_q;
    assign FirstErrIndex  = first_idx_q;
    assign FirstErrFields = first_fields_q;
    assign Overrun        = overrun_q;
    assign DroppedSample  = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_system_response_checker.sv
// ============================================================================
// Module  : tb_alu_system_response_checker
// Purpose : Directed scoreboard bench for the ALU_System response checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_system_response_checker;
    import alu_check_pkg::*;

    localparam int AW = 2;
    localparam int EW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               sv = 1'b0;
    logic [7:0]         a_out = '0, b_out = '0, alu_out = '0, address = '0, mem_out = '0;
    logic [3:0]         flags = '0;
    logic [15:0]        ir_out = '0;
    logic               exp_rd;
    logic [AW-1:0]      exp_addr;
    logic [ENTRY_W-1:0] exp_data = '0;
    logic               busy, done, pass, overrun, dropped;
    logic [EW-1:0]      err_count, vec_count;
    logic [AW-1:0]      first_idx;
    logic [6:0]         first_fields;

    logic [ENTRY_W-1:0] mem [4];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          pass;
        logic          ovr;
        logic          drop;
        logic [EW-1:0] err;
        logic [EW-1:0] vec;
        logic [AW-1:0] idx;
        logic [6:0]    fields;
        logic [AW-1:0] addr;
    } exp_t;
    exp_t sb[$];

    alu_system_response_checker #(.ADDR_W(AW), .ERR_W(EW)) dut (
        .Clock(clk), .Reset(rst_n), .Start(start), .SampleValid(sv),
        .AOut(a_out), .BOut(b_out), .ALUOut(alu_out), .ALUOutFlag(flags),
        .Address(address), .MemoryOut(mem_out), .IROut(ir_out),
        .ExpRd(exp_rd), .ExpAddr(exp_addr), .ExpData(exp_data),
        .Busy(busy), .Done(done), .Pass(pass), .ErrCount(err_count),
        .VectorCount(vec_count), .FirstErrIndex(first_idx),
        .FirstErrFields(first_fields), .Overrun(overrun), .DroppedSample(dropped)
    );

    always #5 clk = ~clk;

    // Expected-response memory: one cycle read latency
    always @(posedge clk) if (exp_rd) exp_data <= mem[exp_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] ent(input logic last, input logic [6:0] fen,
                                               input logic [OBS_W-1:0] v);
        return {last, fen, v};
    endfunction

    task automatic drive_obs(input logic [OBS_W-1:0] v);
        {a_out, b_out, alu_out, flags, address, mem_out, ir_out} = v;
    endtask

    // Leaves the caller at the negedge just after Start was sampled
    task automatic start_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
    endtask

    // One strobe then a 3-cycle gap; optional stray Start lands in FETCH
    task automatic sample(input logic [OBS_W-1:0] v, input logic poke_start);
        drive_obs(v);
        sv = 1'b1;
        @(negedge clk) sv = 1'b0;
        start = poke_start;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_run(input string tag);
        exp_t e;
        int   k = 0;
        while (!done && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_sb_avail"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_done"},    32'(done),         32'd1);
            chk({tag, "_busy"},    32'(busy),         32'd0);
            chk({tag, "_pass"},    32'(pass),         32'(e.pass));
            chk({tag, "_ovr"},     32'(overrun),      32'(e.ovr));
            chk({tag, "_drop"},    32'(dropped),      32'(e.drop));
            chk({tag, "_err"},     32'(err_count),    32'(e.err));
            chk({tag, "_vec"},     32'(vec_count),    32'(e.vec));
            chk({tag, "_idx"},     32'(first_idx),    32'(e.idx));
            chk({tag, "_fields"},  32'(first_fields), 32'(e.fields));
            chk({tag, "_addr"},    32'(exp_addr),     32'(e.addr));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),         32'd0);
        chk({tag, "_done"},   32'(done),         32'd0);
        chk({tag, "_pass"},   32'(pass),         32'd0);
        chk({tag, "_err"},    32'(err_count),    32'd0);
        chk({tag, "_vec"},    32'(vec_count),    32'd0);
        chk({tag, "_idx"},    32'(first_idx),    32'd0);
        chk({tag, "_fields"}, 32'(first_fields), 32'd0);
        chk({tag, "_ovr"},    32'(overrun),      32'd0);
        chk({tag, "_drop"},   32'(dropped),      32'd0);
        chk({tag, "_addr"},   32'(exp_addr),     32'd0);
        chk({tag, "_exprd"},  32'(exp_rd),       32'd0);
    endtask

    logic [OBS_W-1:0] v [4];
    logic [OBS_W-1:0] o1;

    initial begin
        for (int i = 0; i < 4; i++) v[i] = OBS_W'({$urandom(), $urandom()});
        v[1][ALU_LSB +: 8] = 8'h2A;
        o1 = v[1];
        o1[ALU_LSB +: 8] = 8'h2B;

        #12;
        chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Strobe in IDLE is dropped
        @(negedge clk) sv = 1'b1;
        @(negedge clk) sv = 1'b0;
        chk("idle_drop", 32'(dropped), 32'd1);
        chk("idle_vec",  32'(vec_count), 32'd0);

        // All match, with a stray Start mid-run
        mem[0] = ent(1'b0, 7'h7F, v[0]);
        mem[1] = ent(1'b0, 7'h7F, v[1]);
        mem[2] = ent(1'b1, 7'h7F, v[2]);
        mem[3] = ent(1'b0, 7'h7F, v[3]);
        sb.push_back('{pass:1'b1, ovr:1'b0, drop:1'b0, err:2'd0, vec:2'd3, idx:2'd0, fields:7'd0, addr:2'd2});
        start_run();
        settle();
        sample(v[0], 1'b1);
        sample(v[1], 1'b0);
        sample(v[2], 1'b0);
        finish_run("match");

        // Single ALUOut mismatch on entry 1
        sb.push_back('{pass:1'b0, ovr:1'b0, drop:1'b0, err:2'd1, vec:2'd3, idx:2'd1, fields:7'b0010000, addr:2'd2});
        start_run();
        settle();
        sample(v[0], 1'b0);
        sample(o1,   1'b0);
        sample(v[2], 1'b0);
        finish_run("single");

        // Same mismatch with ALUOut masked off
        mem[1] = ent(1'b0, 7'b1101111, v[1]);
        sb.push_back('{pass:1'b1, ovr:1'b0, drop:1'b0, err:2'd0, vec:2'd3, idx:2'd0, fields:7'd0, addr:2'd2});
        start_run();
        settle();
        sample(v[0], 1'b0);
        sample(o1,   1'b0);
        sample(v[2], 1'b0);
        finish_run("dontcare");

        // Early strobe dropped; first-failure latch must not be overwritten
        mem[0] = ent(1'b0, 7'h7F, v[0]);
        mem[1] = ent(1'b1, 7'h7F, v[1]);
        sb.push_back('{pass:1'b0, ovr:1'b0, drop:1'b1, err:2'd2, vec:2'd2, idx:2'd0, fields:7'b0001000, addr:2'd1});
        start_run();
        drive_obs(v[0]);
        sv = 1'b1;
        @(negedge clk) sv = 1'b0;
        @(negedge clk);
        sample(v[0] ^ (60'h1 << FLAG_LSB), 1'b0);
        sample(v[1] ^ (60'h1 << AOUT_LSB), 1'b0);
        finish_run("dropped");

        // Overrun with no errors (BOut mismatch masked), then with IROut errors
        for (int pass_n = 0; pass_n < 2; pass_n++) begin
            for (int i = 0; i < 4; i++) mem[i] = ent(1'b0, 7'b1011111, v[i]);
            if (pass_n == 0)
                sb.push_back('{pass:1'b0, ovr:1'b1, drop:1'b0, err:2'd0, vec:2'd3, idx:2'd0, fields:7'd0, addr:2'd3});
            else
                sb.push_back('{pass:1'b0, ovr:1'b1, drop:1'b0, err:2'd3, vec:2'd3, idx:2'd0, fields:7'b0000001, addr:2'd3});
            start_run();
            settle();
            for (int i = 0; i < 4; i++)
                sample(v[i] ^ (60'h1 << BOUT_LSB) ^ ((pass_n == 1) ? 60'h1 : 60'h0), 1'b0);
            finish_run(pass_n == 0 ? "overrun" : "overrun_sat");
        end

        // Reset while ARMED after two samples with one error
        mem[0] = ent(1'b0, 7'h7F, v[0]);
        mem[1] = ent(1'b0, 7'h7F, v[1]);
        mem[2] = ent(1'b1, 7'h7F, v[2]);
        start_run();
        settle();
        sample(v[0], 1'b0);
        sample(o1,   1'b0);
        chk("prereset_busy", 32'(busy),      32'd1);
        chk("prereset_err",  32'(err_count), 32'd1);
        chk("prereset_vec",  32'(vec_count), 32'd2);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk) rst_n = 1'b1;
        sb.push_back('{pass:1'b1, ovr:1'b0, drop:1'b0, err:2'd0, vec:2'd3, idx:2'd0, fields:7'd0, addr:2'd2});
        start_run();
        settle();
        sample(v[0], 1'b0);
        sample(v[1], 1'b0);
        sample(v[2], 1'b0);
        finish_run("rerun");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
